// File: rtl/timer_seq_pkg.sv
// -----------------------------------------------------------------------------
// timer_seq_pkg
// Shared definitions for timer_sequencer: FSM state encoding, the interval
// timer register map, and the control-register bit masks / command words.
// Optional feature macro: TIMER_SEQ_PAUSE_EN adds the pause-related states.
// -----------------------------------------------------------------------------
package timer_seq_pkg;

`ifdef TIMER_SEQ_PAUSE_EN
    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RUN,
        S_CLR,
        S_STOP,
        S_WR_PAUSE,
        S_PAUSED
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RUN,
        S_CLR,
        S_STOP
    } state_e;
`endif

    // Timer register addresses
    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    // Control register bit masks
    localparam logic [15:0] CTRL_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_CONT  = 16'h0002;
    localparam logic [15:0] CTRL_START = 16'h0004;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    // Control command words
    localparam logic [15:0] CTRL_RUN_WORD   = CTRL_ITO | CTRL_CONT | CTRL_START; // 0x0007
    localparam logic [15:0] CTRL_STOP_WORD  = CTRL_STOP;                         // 0x0008
    localparam logic [15:0] CTRL_PAUSE_WORD = CTRL_ITO | CTRL_CONT | CTRL_STOP;  // 0x000B

endpackage

// File: rtl/timer_sequencer.sv
// -----------------------------------------------------------------------------
// timer_sequencer
// Avalon-MM write master that programs an interval timer for a countdown of
// N timer periods: writes the period, starts continuous mode with interrupts,
// acknowledges each timeout, and stops the timer when the count reaches zero.
//
// Parameters:
//   PERIOD          timer period in clk cycles (1..2^32); PERIOD-1 is written
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   start           one-cycle countdown request (honoured only in IDLE)
//   load_ticks      countdown length, sampled when start is accepted
//   abort           stop countdown from any non-IDLE state
//   pause, resume   pause control (only with TIMER_SEQ_PAUSE_EN)
//   tmr_irq         timer interrupt, level
//   tmr_*           timer slave write port (3-bit address, 16-bit data)
//   busy            high in every state except IDLE
//   tick            one-cycle pulse per acknowledged timeout
//   done            one-cycle pulse on completion, abort, or zero-length start
//   ticks_left      remaining ticks
//
// Optional feature macro: TIMER_SEQ_PAUSE_EN (pause/resume support).
// All outputs are registered; bus outputs are a registered decode of the next
// state, so each write is visible exactly during the cycle its state is held.
// -----------------------------------------------------------------------------
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter logic [32:0] PERIOD = 33'd50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] load_ticks,
    input  logic        abort,
`ifdef TIMER_SEQ_PAUSE_EN
    input  logic        pause,
    input  logic        resume,
`endif
    input  logic        tmr_irq,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    output logic        busy,
    output logic        tick,
    output logic        done,
    output logic [15:0] ticks_left
);

    localparam logic [31:0] PERIOD_M1 = 32'(PERIOD - 33'd1);

    state_e      state_q, state_d;
    logic [2:0]  addr_q, addr_d;
    logic        cs_q, cs_d;
    logic [15:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        tick_q, tick_d;
    logic        done_q, done_d;
    logic [15:0] ticks_q, ticks_d;

    logic start_ok;
    logic start_zero;

    assign start_ok   = (state_q == S_IDLE) && start && (load_ticks != 16'd0);
    assign start_zero = (state_q == S_IDLE) && start && (load_ticks == 16'd0);

    // Next-state logic
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_ok) state_d = S_WR_PL;
            S_WR_PL:   state_d = abort ? S_STOP : S_WR_PH;
            S_WR_PH:   state_d = abort ? S_STOP : S_WR_CTRL;
            S_WR_CTRL: state_d = abort ? S_STOP : S_RUN;
            S_RUN: begin
                if (abort)        state_d = S_STOP;
                else if (tmr_irq) state_d = S_CLR;
`ifdef TIMER_SEQ_PAUSE_EN
                else if (pause)   state_d = S_WR_PAUSE;
`endif
            end
            // ticks_q was already decremented on entry to CLR
            S_CLR:     state_d = (abort || ticks_q == 16'd0) ? S_STOP : S_RUN;
            S_STOP:    state_d = S_IDLE;
`ifdef TIMER_SEQ_PAUSE_EN
            S_WR_PAUSE: state_d = abort ? S_STOP : S_PAUSED;
            S_PAUSED: begin
                if (abort)       state_d = S_STOP;
                else if (resume) state_d = S_WR_CTRL;
            end
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // Bus and status decode of the next state
    always_comb begin
        cs_d   = 1'b0;
        addr_d = TMR_STATUS;
        data_d = 16'h0000;
        case (state_d)
            S_WR_PL: begin
                cs_d   = 1'b1;
                addr_d = TMR_PERIODL;
                data_d = PERIOD_M1[15:0];
            end
            S_WR_PH: begin
                cs_d   = 1'b1;
                addr_d = TMR_PERIODH;
                data_d = PERIOD_M1[31:16];
            end
            S_WR_CTRL: begin
                cs_d   = 1'b1;
                addr_d = TMR_CONTROL;
                data_d = CTRL_RUN_WORD;
            end
            S_CLR: begin
                cs_d   = 1'b1;
                addr_d = TMR_STATUS;
                data_d = 16'h0000;
            end
            S_STOP: begin
                cs_d   = 1'b1;
                addr_d = TMR_CONTROL;
                data_d = CTRL_STOP_WORD;
            end
`ifdef TIMER_SEQ_PAUSE_EN
            S_WR_PAUSE: begin
                cs_d   = 1'b1;
                addr_d = TMR_CONTROL;
                data_d = CTRL_PAUSE_WORD;
            end
`endif
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        tick_d = (state_d == S_CLR);
        done_d = (state_d == S_STOP) || start_zero;

        // CLR is only entered from RUN, where ticks_q is at least 1.
        ticks_d = ticks_q;
        if (start_ok)                ticks_d = load_ticks;
        else if (state_d == S_CLR)   ticks_d = ticks_q - 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= TMR_STATUS;
            cs_q    <= 1'b0;
            data_q  <= 16'h0000;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            ticks_q <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            ticks_q <= ticks_d;
        end
    end

    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = ~cs_q;
    assign tmr_writedata  = data_q;
    assign busy           = busy_q;
    assign tick           = tick_q;
    assign done           = done_q;
    assign ticks_left     = ticks_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_timer_sequencer
// Directed bench for timer_sequencer with PERIOD=50 and a behavioural model
// of the interval timer (period registers, continuous countdown, timeout flag,
// ITO-gated level interrupt). Stimulus and sampling happen 1 time unit after
// the falling clock edge, away from the active rising edge.
// Define TIMER_SEQ_PAUSE_EN to also exercise pause/resume.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] load_ticks;
    logic        abort;
`ifdef TIMER_SEQ_PAUSE_EN
    logic        pause;
    logic        resume;
`endif
    logic        tmr_irq = 1'b0;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        busy;
    logic        tick;
    logic        done;
    logic [15:0] ticks_left;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    timer_sequencer #(.PERIOD(33'd50)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .load_ticks     (load_ticks),
        .abort          (abort),
`ifdef TIMER_SEQ_PAUSE_EN
        .pause          (pause),
        .resume         (resume),
`endif
        .tmr_irq        (tmr_irq),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .busy           (busy),
        .tick           (tick),
        .done           (done),
        .ticks_left     (ticks_left)
    );

    // Interval timer model: evaluated on the falling edge, when the DUT's
    // registered bus outputs are stable.
    logic [15:0] m_pl  = 16'd0;
    logic [15:0] m_ph  = 16'd0;
    logic [31:0] m_cnt = 32'd0;
    logic        m_run = 1'b0;
    logic        m_to  = 1'b0;
    logic        m_ito = 1'b0;

    always @(negedge clk) begin
        if (m_run) begin
            if (m_cnt == 32'd0) begin
                m_to  = 1'b1;
                m_cnt = {m_ph, m_pl};
            end else begin
                m_cnt = m_cnt - 32'd1;
            end
        end
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: m_to = 1'b0;
                3'd1: begin
                    m_ito = tmr_writedata[0];
                    if (tmr_writedata[3])      m_run = 1'b0;
                    else if (tmr_writedata[2]) m_run = 1'b1;
                end
                3'd2: begin
                    m_pl  = tmr_writedata;
                    m_cnt = {m_ph, tmr_writedata};
                end
                3'd3: begin
                    m_ph  = tmr_writedata;
                    m_cnt = {tmr_writedata, m_pl};
                end
                default: ;
            endcase
        end
        tmr_irq = m_to & m_ito;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    // Steps until tick is seen (bounded); n = number of steps taken.
    task automatic wait_tick(output int n);
        n = 0;
        while (!tick && n < 300) begin
            nstep();
            n++;
        end
    endtask

    task automatic check_write(input string tag, input logic [2:0] a, input logic [15:0] d);
        check({tag, "_cs"},   32'(tmr_chipselect), 32'd1);
        check({tag, "_wrn"},  32'(tmr_write_n),    32'd0);
        check({tag, "_addr"}, 32'(tmr_address),    32'(a));
        check({tag, "_data"}, 32'(tmr_writedata),  32'(d));
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_cs"},   32'(tmr_chipselect), 32'd0);
        check({tag, "_wrn"},  32'(tmr_write_n),    32'd1);
        check({tag, "_addr"}, 32'(tmr_address),    32'd0);
        check({tag, "_data"}, 32'(tmr_writedata),  32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_idle_bus(tag);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_tick"},  32'(tick),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_ticks"}, 32'(ticks_left), 32'd0);
    endtask

    // Pulses start with the given length and steps into the WR_PL cycle.
    task automatic kick(input logic [15:0] len);
        start      = 1'b1;
        load_ticks = len;
        nstep();
        start      = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;

        reset_n    = 1'b0;
        start      = 1'b0;
        load_ticks = 16'd0;
        abort      = 1'b0;
`ifdef TIMER_SEQ_PAUSE_EN
        pause      = 1'b0;
        resume     = 1'b0;
`endif
        repeat (2) nstep();
        check_reset_vals("rst");
        reset_n = 1'b1;
        nstep();

        // ---- setup sequence and full countdown (3 ticks) ----
        kick(16'd3);
        check_write("wr_pl", 3'd2, 16'h0031);
        check("wr_pl_busy",  32'(busy),       32'd1);
        check("wr_pl_ticks", 32'(ticks_left), 32'd3);
        nstep();
        check_write("wr_ph", 3'd3, 16'h0000);
        nstep();
        check_write("wr_ctrl", 3'd1, 16'h0007);
        nstep();
        check_idle_bus("run");

        wait_tick(n);
        check("t1_seen", 32'(tick), 32'd1);
        check("t1_lat_ok", 32'((n + 1) >= 49 && (n + 1) <= 53), 32'd1);
        check_write("clr1", 3'd0, 16'h0000);
        check("t1_ticks", 32'(ticks_left), 32'd2);
        nstep();
        check("t1_pulse_len", 32'(tick), 32'd0);
        wait_tick(n);
        check("t2_seen", 32'(tick), 32'd1);
        check("t2_spacing", 32'(n + 1), 32'd50);
        check_write("clr2", 3'd0, 16'h0000);
        check("t2_ticks", 32'(ticks_left), 32'd1);
        nstep();
        wait_tick(n);
        check("t3_seen", 32'(tick), 32'd1);
        check("t3_spacing", 32'(n + 1), 32'd50);
        check("t3_ticks", 32'(ticks_left), 32'd0);
        nstep();
        check_write("stop", 3'd1, 16'h0008);
        check("stop_done",  32'(done),       32'd1);
        check("stop_tick",  32'(tick),       32'd0);
        check("stop_ticks", 32'(ticks_left), 32'd0);
        nstep();
        check("fin_busy",  32'(busy),       32'd0);
        check("fin_done",  32'(done),       32'd0);
        check("fin_ticks", 32'(ticks_left), 32'd0);
        check_idle_bus("fin");

        // ---- abort with ticks_left=2, start while busy ignored ----
        kick(16'd3);
        repeat (3) nstep();
        wait_tick(n);
        check("ab_t1_seen", 32'(tick), 32'd1);
        start      = 1'b1;
        load_ticks = 16'd9;
        nstep();
        start      = 1'b0;
        check("busy_start_ticks", 32'(ticks_left), 32'd2);
        check("busy_start_cs",    32'(tmr_chipselect), 32'd0);
        check("busy_start_busy",  32'(busy), 32'd1);
        abort = 1'b1;
        nstep();
        abort = 1'b0;
        check_write("ab_stop", 3'd1, 16'h0008);
        check("ab_done",  32'(done),       32'd1);
        check("ab_tick",  32'(tick),       32'd0);
        check("ab_ticks", 32'(ticks_left), 32'd2);
        nstep();
        check("ab_idle_busy",  32'(busy),       32'd0);
        check("ab_idle_ticks", 32'(ticks_left), 32'd2);

        // ---- start with load_ticks=0: done only ----
        kick(16'd0);
        check("z_done", 32'(done), 32'd1);
        check("z_busy", 32'(busy), 32'd0);
        check_idle_bus("z");
        nstep();
        check("z_done_end", 32'(done), 32'd0);
        check("z_cs_end",   32'(tmr_chipselect), 32'd0);

        // ---- asynchronous reset during WR_PH ----
        kick(16'd5);
        nstep();
        check("r_in_ph_addr", 32'(tmr_address), 32'd3);
        reset_n = 1'b0;
        #1;
        check_reset_vals("r_async");
        nstep();
        reset_n = 1'b1;
        nstep();
        check("r_after_busy", 32'(busy), 32'd0);
        check("r_after_cs",   32'(tmr_chipselect), 32'd0);
        kick(16'd1);
        check_write("r_restart_pl", 3'd2, 16'h0031);
        repeat (3) nstep();
        wait_tick(n);
        check("r_t_seen",  32'(tick),       32'd1);
        check("r_t_ticks", 32'(ticks_left), 32'd0);
        nstep();
        check("r_done", 32'(done), 32'd1);
        nstep();

`ifdef TIMER_SEQ_PAUSE_EN
        // ---- pause mid-period, resume continues the remaining period ----
        kick(16'd2);
        nstep();
        nstep();
        check_write("p_ctrl", 3'd1, 16'h0007);
        repeat (20) nstep();
        check("p_irq_low", 32'(tmr_irq), 32'd0);
        pause = 1'b1;
        nstep();
        pause = 1'b0;
        check_write("p_wr", 3'd1, 16'h000B);
        cnt = 0;
        repeat (100) begin
            nstep();
            if (tick) cnt++;
        end
        check("p_no_tick", 32'(cnt), 32'd0);
        check("p_busy",    32'(busy), 32'd1);
        check("p_ticks",   32'(ticks_left), 32'd2);
        resume = 1'b1;
        nstep();
        resume = 1'b0;
        check_write("p_resume", 3'd1, 16'h0007);
        wait_tick(n);
        check("p_t1_seen", 32'(tick), 32'd1);
        check("p_t1_rem_ok", 32'(n >= 27 && n <= 33), 32'd1);
        check("p_t1_ticks", 32'(ticks_left), 32'd1);
        nstep();
        wait_tick(n);
        check("p_t2_seen", 32'(tick), 32'd1);
        nstep();
        check("p_done", 32'(done), 32'd1);
        nstep();
`endif

        // ---- abort and tmr_irq together in RUN: abort wins ----
        kick(16'd3);
        repeat (3) nstep();
        n = 0;
        while (!tmr_irq && n < 300) begin
            nstep();
            n++;
        end
        check("ai_irq_seen", 32'(tmr_irq), 32'd1);
        abort = 1'b1;
        nstep();
        abort = 1'b0;
        check_write("ai_stop", 3'd1, 16'h0008);
        check("ai_tick",  32'(tick),       32'd0);
        check("ai_done",  32'(done),       32'd1);
        check("ai_ticks", 32'(ticks_left), 32'd3);
        nstep();
        check("ai_busy", 32'(busy), 32'd0);
        check("ai_tick2", 32'(tick), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Avalon-MM write master that programs and services the interval timer peripheral for a countdown of N timer periods. It sits between game/score control logic and the timer's 3-bit-address, 16-bit slave port. It writes the period, starts continuous mode with interrupts enabled, and acknowledges each timeout. It reports the remaining ticks and stops the timer at zero.

## Interface
Parameters:
- PERIOD, 50000: timer period in clk cycles; the value written to the timer is PERIOD-1. Legal range is 1..2^32.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a countdown; honoured only in IDLE
- load_ticks  in  16  countdown length, sampled when start is accepted
- abort  in  1  stops the countdown from any non-IDLE state
- pause  in  1  pause request; present only with TIMER_SEQ_PAUSE_EN
- resume  in  1  resume request; present only with TIMER_SEQ_PAUSE_EN
- tmr_irq  in  1  timer interrupt (level)
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer chip select
- tmr_write_n  out  1  timer write strobe, active low
- tmr_writedata  out  16  timer write data
- busy  out  1  high in every state except IDLE
- tick  out  1  one-cycle pulse per acknowledged timeout
- done  out  1  one-cycle pulse when the countdown completes or is aborted
- ticks_left  out  16  remaining ticks

## Operation
- Timer register map:
  - 0 = status; writing any value clears the timeout.
  - 1 = control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 = period low.
  - 3 = period high.
- Each timer write occupies exactly one cycle: chipselect=1 and write_n=0 with address and data valid. The slave has no waitrequest.
- FSM states:
  - IDLE: start with load_ticks≠0 goes to WR_PL and loads ticks_left. start with load_ticks=0 pulses done with no bus activity.
  - WR_PL: writes (PERIOD-1)[15:0] to address 2, then goes to WR_PH.
  - WR_PH: writes (PERIOD-1)[31:16] to address 3, then goes to WR_CTRL.
  - WR_CTRL: writes 0x0007 to address 1, then goes to RUN.
  - RUN: tmr_irq=1 goes to CLR.
  - CLR: writes 0x0000 to address 0, decrements ticks_left and pulses tick. If ticks_left was 1, goes to STOP; otherwise goes to RUN.
  - STOP: writes 0x0008 to address 1, pulses done, then goes to IDLE.
- abort in any non-IDLE state except STOP goes to STOP on the next cycle. ticks_left holds its value.
- Priority in RUN: abort > tmr_irq > pause.
- start while busy is ignored.
- ticks_left stays valid after completion or abort until the next accepted start.
- When not writing, the bus is idle: chipselect=0, write_n=1, address=0, writedata=0.

## Timing
- All outputs are registered.
- Reset values: tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, busy=0, tick=0, done=0, ticks_left=0. State resets to IDLE.
- Reset mid-sequence leaves the timer in whatever state it was last written to. Firmware or the next start reprograms it.
- start accepted at edge E gives: WR_PL write in cycle E+1, WR_PH in E+2, WR_CTRL in E+3, RUN from E+4.
- The first tmr_irq follows the control write by about PERIOD cycles.
- From tmr_irq high in RUN, the status write occurs 1 cycle later. tmr_irq is low on the cycle after CLR, so one timeout is never counted twice.
- tick is coincident with the CLR cycle. done is coincident with the STOP cycle.
- Total tick latency: (ticks × PERIOD) plus fixed overhead of 4 setup cycles and 1 stop cycle.

## Configuration
- Macro: TIMER_SEQ_PAUSE_EN.
- Defined:
  - Adds the pause and resume ports and the states WR_PAUSE and PAUSED.
  - pause in RUN (no abort, tmr_irq=0) goes to WR_PAUSE. WR_PAUSE writes 0x000B to address 1, then goes to PAUSED.
  - In PAUSED, resume goes to WR_CTRL, which writes 0x0007 and returns to RUN. The timer counter is not reloaded, so the remaining period continues.
  - A timeout latched during the pause stays pending and is serviced after resume.
  - abort in PAUSED goes to STOP.
- Undefined: no pause or resume ports and no extra states. Behaviour is otherwise identical.

## Structure
- timer_seq_pkg holds:
  - the state enum;
  - the timer address constants TMR_STATUS=0, TMR_CONTROL=1, TMR_PERIODL=2, TMR_PERIODH=3;
  - the control bit constants CTRL_ITO, CTRL_CONT, CTRL_START, CTRL_STOP;
  - the control words CTRL_RUN_WORD=0x7 and CTRL_STOP_WORD=0x8.
- Single module. No sub-module is needed; the bus driver is a registered decode of the next state.

## Test plan
- Setup write sequence: PERIOD=50, start with load_ticks=3. Required writes: address 2 data 0x0031, address 3 data 0x0000, address 1 data 0x0007, each exactly one cycle, in consecutive cycles E+1..E+3.
- Full countdown: with a timer model, expect 3 tick pulses about 50 cycles apart, each paired with a status write. Then ticks_left=0, a control write of 0x0008 coincident with done, and busy=0.
- Abort: abort while ticks_left=2 in RUN. Required: STOP write on the next cycle, done pulse, ticks_left stays 2, no tick.
- Simultaneous and ignored inputs:
  - abort and tmr_irq high in the same RUN cycle: STOP, no CLR.
  - start while busy: ignored.
  - start with load_ticks=0: done only, no bus writes.
- Reset: deassert reset_n during WR_PH. All outputs take their reset values immediately (asynchronously), and the state is IDLE after release.
- Pause (TIMER_SEQ_PAUSE_EN defined):
  - pause mid-period: write of 0x000B, no tick while paused.
  - resume: write of 0x0007, and the next tick arrives after the remaining portion of the period.
